// File: rtl/tdc_pkg.sv
// rtl/tdc_pkg.sv - shared types, constants and helpers for the TDC transmit scheduler
//
// Purpose: common definitions imported by tdc_tx_scheduler.
//   CH_ID_W      width of the channel tag prepended to each measurement
//   BUSY_TIMEOUT cycles to wait for the UART to raise busy after tx_start
//   tx_state_t   TX state machine encoding
//   tx_word_t    {ch_id, meas} layout at the default 40-bit measurement width
//   sat_add16    saturating add used by the drop counter
package tdc_pkg;

   localparam int CH_ID_W      = 8;
   localparam int BUSY_TIMEOUT = 4;
   localparam int MEAS_W_DEF   = 40;

   typedef enum logic [1:0] {
      IDLE,
      WAIT_BUSY,
      WAIT_DONE
   } tx_state_t;

   typedef struct packed {
      logic [CH_ID_W-1:0]    ch_id;
      logic [MEAS_W_DEF-1:0] meas;
   } tx_word_t;

   function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [4:0] b);
      logic [16:0] sum;
      sum = {1'b0, a} + {12'b0, b};
      return sum[16] ? 16'hFFFF : sum[15:0];
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - synchronous FIFO with wrap-bit pointers and first-word-fall-through read
//
// Purpose: shared entry queue between the channel arbiter and the TX state machine.
// Ports:
//   clk_200m, rst_n  clock, asynchronous active-low reset (pointers only)
//   push, wdata      write request and data; accepted when not full, or when full with a pop
//   pop, rdata       read request; rdata always shows the oldest entry
//   full, empty      occupancy flags
//   level            current occupancy, 0..DEPTH
module sync_fifo #(
   parameter int WIDTH = 48,
   parameter int DEPTH = 8
) (
   input  logic                     clk_200m,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
   assign do_pop  = pop && !empty;
   // At full, a concurrent pop frees the slot being written; at empty the
   // pop is ignored so freshly pushed data is never read in the same cycle.
   assign do_push = push && (!full || do_pop);
   assign level   = wr_ptr - rd_ptr;
   assign rdata   = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk_200m or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk_200m) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
   end

endmodule

// File: rtl/tdc_tx_scheduler.sv
// rtl/tdc_tx_scheduler.sv - multi-channel TDC measurement holder, arbiter and rate-limited UART feeder
//
// Purpose: holds the latest measurement per channel, moves them round-robin into a
// shared FIFO and hands tagged words to uart_tx under an optional rate limit.
// Ports:
//   clk_200m, rst_n  200 MHz clock, asynchronous active-low reset
//   meas, meas_valid per-channel measurements (channel i at [i*MEAS_W +: MEAS_W]) and strobes
//   queue_mode       0 = latest-only (single outstanding entry), 1 = FIFO queue
//   rate_en          1 = enforce CLKS_PER_TX cycles between tx_start pulses
//   tx_data          {ch_id, measurement}, held from tx_start to the next tx_start
//   tx_start         one-cycle start pulse to the UART
//   tx_busy          UART busy
//   drop_count       saturating count of discarded measurements
//   fifo_level       shared FIFO occupancy
module tdc_tx_scheduler
   import tdc_pkg::*;
#(
   parameter int NUM_CH      = 4,
   parameter int MEAS_W      = 40,
   parameter int FIFO_DEPTH  = 8,
   parameter int CLKS_PER_TX = 10_000_000,
   parameter int RATE_W      = 24
) (
   input  logic                            clk_200m,
   input  logic                            rst_n,
   input  logic [NUM_CH*MEAS_W-1:0]        meas,
   input  logic [NUM_CH-1:0]               meas_valid,
   input  logic                            queue_mode,
   input  logic                            rate_en,
   output logic [CH_ID_W+MEAS_W-1:0]       tx_data,
   output logic                            tx_start,
   input  logic                            tx_busy,
   output logic [15:0]                     drop_count,
   output logic [$clog2(FIFO_DEPTH):0]     fifo_level
);

   localparam int PTR_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int WORD_W = CH_ID_W + MEAS_W;
   localparam int INC_W  = $clog2(NUM_CH + 2);
   localparam int BW_W   = $clog2(BUSY_TIMEOUT) + 1;

   logic [MEAS_W-1:0] hold [NUM_CH];
   logic [NUM_CH-1:0] pend;
   logic [PTR_W-1:0]  rr_ptr;
   logic [RATE_W-1:0] rate_cnt;
   tx_state_t         state;
   logic [BW_W-1:0]   busy_wait;

   logic              fifo_full;
   logic              fifo_empty;
   logic              fifo_push;
   logic              fifo_pop;
   logic [WORD_W-1:0] fifo_wdata;
   logic [WORD_W-1:0] fifo_rdata;

   logic              arb_ok;
   logic              grant_vld;
   logic [PTR_W-1:0]  grant_idx;
   int                arb_idx;
   logic              can_tx;
   logic              timeout_drop;
   logic [INC_W-1:0]  drop_inc;

   // Latest-only mode admits a new entry only when nothing is queued or in flight.
   assign arb_ok = !fifo_full && (queue_mode || (fifo_empty && state == IDLE));

   // Scan offsets from high to low so the pending channel nearest rr_ptr wins.
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      arb_idx   = 0;
      for (int k = NUM_CH - 1; k >= 0; k--) begin
         arb_idx = int'(rr_ptr) + k;
         if (arb_idx >= NUM_CH) arb_idx = arb_idx - NUM_CH;
         if (pend[arb_idx]) begin
            grant_vld = 1'b1;
            grant_idx = PTR_W'(arb_idx);
         end
      end
      if (!arb_ok) grant_vld = 1'b0;
   end

   assign fifo_push  = grant_vld;
   assign fifo_wdata = {CH_ID_W'(grant_idx), hold[grant_idx]};

   // A strobe on the channel being granted reloads the register and keeps pend set;
   // the old value has already gone into the FIFO.
   always_ff @(posedge clk_200m or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_CH; i++) hold[i] <= '0;
         pend   <= '0;
         rr_ptr <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (meas_valid[i]) begin
               hold[i] <= meas[i*MEAS_W +: MEAS_W];
               pend[i] <= 1'b1;
            end else if (fifo_push && grant_idx == PTR_W'(i)) begin
               pend[i] <= 1'b0;
            end
         end
         if (fifo_push) rr_ptr <= (int'(grant_idx) == NUM_CH - 1) ? '0 : grant_idx + 1'b1;
      end
   end

   sync_fifo #(
      .WIDTH (WORD_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_200m (clk_200m),
      .rst_n    (rst_n),
      .push     (fifo_push),
      .wdata    (fifo_wdata),
      .pop      (fifo_pop),
      .rdata    (fifo_rdata),
      .full     (fifo_full),
      .empty    (fifo_empty),
      .level    (fifo_level)
   );

   // The counter clears on the same edge that loads tx_start, so spacing is
   // measured from each pulse.
   always_ff @(posedge clk_200m or negedge rst_n) begin
      if (!rst_n) begin
         rate_cnt <= '0;
      end else if (fifo_pop) begin
         rate_cnt <= '0;
      end else if (rate_cnt < RATE_W'(CLKS_PER_TX)) begin
         rate_cnt <= rate_cnt + 1'b1;
      end
   end

   assign can_tx       = !rate_en || (rate_cnt >= RATE_W'(CLKS_PER_TX));
   assign fifo_pop     = (state == IDLE) && !fifo_empty && can_tx && !tx_busy;
   assign timeout_drop = (state == WAIT_BUSY) && !tx_busy && (busy_wait == BW_W'(BUSY_TIMEOUT - 1));

   always_ff @(posedge clk_200m or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         tx_start  <= 1'b0;
         tx_data   <= '0;
         busy_wait <= '0;
      end else begin
         tx_start <= 1'b0;
         case (state)
            IDLE: begin
               if (fifo_pop) begin
                  tx_data   <= fifo_rdata;
                  tx_start  <= 1'b1;
                  busy_wait <= '0;
                  state     <= WAIT_BUSY;
               end
            end
            WAIT_BUSY: begin
               if (tx_busy)           state     <= WAIT_DONE;
               else if (timeout_drop) state     <= IDLE;
               else                   busy_wait <= busy_wait + 1'b1;
            end
            WAIT_DONE: begin
               if (!tx_busy) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Overwrites of still-pending channels plus a UART that never answered.
   always_comb begin
      drop_inc = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (meas_valid[i] && pend[i] && !(fifo_push && grant_idx == PTR_W'(i)))
            drop_inc = drop_inc + 1'b1;
      end
      if (timeout_drop) drop_inc = drop_inc + 1'b1;
   end

   always_ff @(posedge clk_200m or negedge rst_n) begin
      if (!rst_n) begin
         drop_count <= '0;
      end else if (drop_inc != '0) begin
         drop_count <= sat_add16(drop_count, 5'(drop_inc));
      end
   end

endmodule

// File: tb/tb_tdc_tx_scheduler.sv
// tb/tb_tdc_tx_scheduler.sv - self-checking bench for tdc_tx_scheduler
module tb_tdc_tx_scheduler;

   localparam int NUM_CH  = 4;
   localparam int MEAS_W  = 40;
   localparam int DEPTH   = 4;
   localparam int CLKS    = 100;
   localparam int WORD_W  = 8 + MEAS_W;

   logic                     clk_200m = 1'b0;
   logic                     rst_n = 1'b0;
   logic [NUM_CH*MEAS_W-1:0] meas = '0;
   logic [NUM_CH-1:0]        meas_valid = '0;
   logic                     queue_mode = 1'b1;
   logic                     rate_en = 1'b0;
   logic [WORD_W-1:0]        tx_data;
   logic                     tx_start;
   logic                     tx_busy;
   logic [15:0]              drop_count;
   logic [$clog2(DEPTH):0]   fifo_level;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int t_rel = 0;

   logic              force_busy = 1'b0;
   logic              uart_busy = 1'b0;
   bit                uart_ignore = 1'b0;
   int                busy_len = 10;
   int                busy_left = 0;
   logic [WORD_W-1:0] obs_q [$];
   int                obs_t [$];

   tdc_tx_scheduler #(
      .NUM_CH      (NUM_CH),
      .MEAS_W      (MEAS_W),
      .FIFO_DEPTH  (DEPTH),
      .CLKS_PER_TX (CLKS),
      .RATE_W      (24)
   ) dut (
      .clk_200m   (clk_200m),
      .rst_n      (rst_n),
      .meas       (meas),
      .meas_valid (meas_valid),
      .queue_mode (queue_mode),
      .rate_en    (rate_en),
      .tx_data    (tx_data),
      .tx_start   (tx_start),
      .tx_busy    (tx_busy),
      .drop_count (drop_count),
      .fifo_level (fifo_level)
   );

   always #5 clk_200m = ~clk_200m;
   always @(posedge clk_200m) cyc <= cyc + 1;

   assign tx_busy = force_busy | uart_busy;

   // UART model: records every start pulse and, unless ignoring, stays busy busy_len cycles.
   always @(negedge clk_200m) begin
      if (tx_start) begin
         obs_q.push_back(tx_data);
         obs_t.push_back(cyc);
         if (!uart_ignore) begin
            uart_busy = 1'b1;
            busy_left = busy_len;
         end
      end else if (busy_left > 0) begin
         busy_left = busy_left - 1;
         if (busy_left == 0) uart_busy = 1'b0;
      end
   end

   task automatic tick();
      @(negedge clk_200m);
      #1;
   endtask

   task automatic drive(input int ch, input logic [MEAS_W-1:0] v);
      meas[ch*MEAS_W +: MEAS_W] = v;
      meas_valid[ch] = 1'b1;
   endtask

   function automatic logic [MEAS_W-1:0] rnd_meas();
      return MEAS_W'({$urandom(), $urandom()});
   endfunction

   task automatic do_reset();
      for (int i = 0; i < 300 && uart_busy; i++) tick();
      tick();
      rst_n = 1'b0;
      meas_valid = '0;
      meas = '0;
      force_busy = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;
      t_rel = cyc;
   endtask

   task automatic wait_caps(input int n, input int limit, output bit ok);
      for (int i = 0; i < limit; i++) begin
         if (obs_q.size() >= n) break;
         tick();
      end
      ok = (obs_q.size() >= n);
   endtask

   task automatic test_reset();
      rate_en = 1'b1;
      queue_mode = 1'b1;
      do_reset();
      checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL reset_tx_start: got %b expected 0", tx_start); end
      checks++; if (tx_data !== '0) begin errors++; $display("FAIL reset_tx_data: got %h expected 0", tx_data); end
      checks++; if (drop_count !== 16'd0) begin errors++; $display("FAIL reset_drop: got %0d expected 0", drop_count); end
      checks++; if (fifo_level !== '0) begin errors++; $display("FAIL reset_level: got %0d expected 0", fifo_level); end
   endtask

   task automatic test_first_tx_rate();
      int base;
      bit ok;
      rate_en = 1'b1;
      queue_mode = 1'b1;
      busy_len = 10;
      uart_ignore = 1'b0;
      do_reset();
      base = obs_q.size();
      tick();
      drive(2, 40'h12345);
      tick();
      meas_valid = '0;
      wait_caps(base + 1, 300, ok);
      checks++;
      if (!ok) begin
         errors++; $display("FAIL first_tx_timeout: got %0d starts expected 1", obs_q.size() - base);
      end else begin
         checks++;
         if (obs_t[base] - t_rel < CLKS || obs_t[base] - t_rel > CLKS + 5) begin
            errors++; $display("FAIL first_tx_delay: got %0d cycles expected %0d..%0d", obs_t[base] - t_rel, CLKS, CLKS + 5);
         end
         checks++;
         if (obs_q[base] !== {8'd2, 40'h12345}) begin
            errors++; $display("FAIL first_tx_data: got %h expected %h", obs_q[base], {8'd2, 40'h12345});
         end
      end
      repeat (200) tick();
      checks++; if (obs_q.size() - base != 1) begin errors++; $display("FAIL first_tx_once: got %0d starts expected 1", obs_q.size() - base); end
   endtask

   task automatic test_all_channels();
      int base;
      int peak;
      logic [MEAS_W-1:0] v [NUM_CH];
      rate_en = 1'b0;
      queue_mode = 1'b1;
      busy_len = 10;
      do_reset();
      base = obs_q.size();
      peak = 0;
      tick();
      for (int c = 0; c < NUM_CH; c++) begin
         v[c] = rnd_meas();
         drive(c, v[c]);
      end
      tick();
      meas_valid = '0;
      for (int i = 0; i < 400 && obs_q.size() < base + NUM_CH; i++) begin
         if (int'(fifo_level) > peak) peak = int'(fifo_level);
         tick();
      end
      checks++;
      if (obs_q.size() < base + NUM_CH) begin
         errors++; $display("FAIL all_ch_timeout: got %0d starts expected %0d", obs_q.size() - base, NUM_CH);
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            checks++;
            if (obs_q[base + c] !== {8'(c), v[c]}) begin
               errors++; $display("FAIL all_ch_word%0d: got %h expected %h", c, obs_q[base + c], {8'(c), v[c]});
            end
         end
      end
      checks++; if (drop_count !== 16'd0) begin errors++; $display("FAIL all_ch_drop: got %0d expected 0", drop_count); end
      checks++; if (peak < 3 || peak > 4) begin errors++; $display("FAIL all_ch_peak: got %0d expected 3..4", peak); end
      repeat (20) tick();
   endtask

   task automatic test_random_rr();
      int rr_m;
      int base;
      int n;
      int last;
      int c;
      bit ok;
      logic [3:0] mask;
      logic [MEAS_W-1:0] v [NUM_CH];
      logic [WORD_W-1:0] exp_w [NUM_CH];
      rate_en = 1'b0;
      queue_mode = 1'b1;
      do_reset();
      rr_m = 0;
      for (int r = 0; r < 8; r++) begin
         mask = 4'($urandom_range(1, 15));
         busy_len = $urandom_range(1, 8);
         n = 0;
         last = 0;
         for (int k = 0; k < NUM_CH; k++) v[k] = rnd_meas();
         // Channels strobed together are sent in circular order starting after the last sent one.
         for (int k = 0; k < NUM_CH; k++) begin
            c = (rr_m + k) % NUM_CH;
            if (mask[c]) begin
               exp_w[n] = {8'(c), v[c]};
               n++;
               last = c;
            end
         end
         rr_m = (last + 1) % NUM_CH;
         base = obs_q.size();
         tick();
         for (int k = 0; k < NUM_CH; k++) if (mask[k]) drive(k, v[k]);
         tick();
         meas_valid = '0;
         wait_caps(base + n, 400, ok);
         checks++;
         if (!ok) begin
            errors++; $display("FAIL rr_round%0d_timeout: got %0d starts expected %0d", r, obs_q.size() - base, n);
         end else begin
            for (int k = 0; k < n; k++) begin
               checks++;
               if (obs_q[base + k] !== exp_w[k]) begin
                  errors++; $display("FAIL rr_round%0d_word%0d: got %h expected %h", r, k, obs_q[base + k], exp_w[k]);
               end
            end
         end
         repeat (20) tick();
      end
      checks++; if (drop_count !== 16'd0) begin errors++; $display("FAIL rr_drop: got %0d expected 0", drop_count); end
   endtask

   task automatic test_overwrite_full();
      int base;
      bit ok;
      logic [MEAS_W-1:0] a [DEPTH];
      logic [MEAS_W-1:0] v [3];
      logic [WORD_W-1:0] e;
      rate_en = 1'b0;
      queue_mode = 1'b1;
      busy_len = 3;
      do_reset();
      base = obs_q.size();
      force_busy = 1'b1;
      for (int k = 0; k < DEPTH; k++) begin
         a[k] = rnd_meas();
         tick();
         drive(0, a[k]);
         tick();
         meas_valid = '0;
         repeat (2) tick();
      end
      checks++; if (int'(fifo_level) != DEPTH) begin errors++; $display("FAIL ovr_full_level: got %0d expected %0d", fifo_level, DEPTH); end
      for (int k = 0; k < 3; k++) begin
         v[k] = rnd_meas();
         tick();
         drive(1, v[k]);
      end
      tick();
      meas_valid = '0;
      repeat (3) tick();
      checks++; if (drop_count !== 16'd2) begin errors++; $display("FAIL ovr_drop: got %0d expected 2", drop_count); end
      force_busy = 1'b0;
      wait_caps(base + DEPTH + 1, 300, ok);
      checks++;
      if (!ok) begin
         errors++; $display("FAIL ovr_timeout: got %0d starts expected %0d", obs_q.size() - base, DEPTH + 1);
      end else begin
         for (int k = 0; k <= DEPTH; k++) begin
            e = (k < DEPTH) ? {8'd0, a[k]} : {8'd1, v[2]};
            checks++;
            if (obs_q[base + k] !== e) begin
               errors++; $display("FAIL ovr_word%0d: got %h expected %h", k, obs_q[base + k], e);
            end
         end
      end
      repeat (20) tick();
   endtask

   task automatic test_latest_only();
      int base;
      bit ok;
      logic [MEAS_W-1:0] v [5];
      rate_en = 1'b0;
      queue_mode = 1'b0;
      busy_len = 40;
      do_reset();
      base = obs_q.size();
      for (int k = 0; k < 5; k++) v[k] = rnd_meas();
      tick();
      drive(0, v[0]);
      tick();
      meas_valid = '0;
      wait_caps(base + 1, 50, ok);
      checks++; if (!ok) begin errors++; $display("FAIL latest_first_timeout: got %0d starts expected 1", obs_q.size() - base); end
      for (int k = 1; k < 5; k++) begin
         repeat (5) tick();
         drive(0, v[k]);
         tick();
         meas_valid = '0;
      end
      wait_caps(base + 2, 300, ok);
      repeat (100) tick();
      checks++; if (obs_q.size() - base != 2) begin errors++; $display("FAIL latest_count: got %0d starts expected 2", obs_q.size() - base); end
      if (obs_q.size() - base >= 2) begin
         checks++; if (obs_q[base] !== {8'd0, v[0]}) begin errors++; $display("FAIL latest_word0: got %h expected %h", obs_q[base], {8'd0, v[0]}); end
         checks++; if (obs_q[base + 1] !== {8'd0, v[4]}) begin errors++; $display("FAIL latest_word1: got %h expected %h", obs_q[base + 1], {8'd0, v[4]}); end
      end
      checks++; if (drop_count !== 16'd3) begin errors++; $display("FAIL latest_drop: got %0d expected 3", drop_count); end
      queue_mode = 1'b1;
   endtask

   task automatic test_busy_timeout();
      int base;
      bit ok;
      int chs [3] = '{0, 1, 3};
      logic [MEAS_W-1:0] v [3];
      rate_en = 1'b0;
      queue_mode = 1'b1;
      do_reset();
      uart_ignore = 1'b1;
      base = obs_q.size();
      tick();
      for (int k = 0; k < 3; k++) begin
         v[k] = rnd_meas();
         drive(chs[k], v[k]);
      end
      tick();
      meas_valid = '0;
      wait_caps(base + 3, 100, ok);
      repeat (10) tick();
      checks++;
      if (!ok) begin
         errors++; $display("FAIL timeout_starts: got %0d starts expected 3", obs_q.size() - base);
      end else begin
         for (int k = 0; k < 3; k++) begin
            checks++;
            if (obs_q[base + k] !== {8'(chs[k]), v[k]}) begin
               errors++; $display("FAIL timeout_word%0d: got %h expected %h", k, obs_q[base + k], {8'(chs[k]), v[k]});
            end
         end
         for (int k = 1; k < 3; k++) begin
            checks++;
            if (obs_t[base + k] - obs_t[base + k - 1] != 5) begin
               errors++; $display("FAIL timeout_spacing%0d: got %0d expected 5", k, obs_t[base + k] - obs_t[base + k - 1]);
            end
         end
      end
      checks++; if (drop_count !== 16'd3) begin errors++; $display("FAIL timeout_drop: got %0d expected 3", drop_count); end
      checks++; if (fifo_level !== '0) begin errors++; $display("FAIL timeout_level: got %0d expected 0", fifo_level); end
      uart_ignore = 1'b0;
   endtask

   task automatic test_reset_mid_frame();
      int base;
      bit ok;
      logic [MEAS_W-1:0] v;
      rate_en = 1'b1;
      queue_mode = 1'b1;
      busy_len = 30;
      do_reset();
      base = obs_q.size();
      tick();
      for (int c = 0; c < NUM_CH; c++) drive(c, rnd_meas());
      tick();
      meas_valid = '0;
      wait_caps(base + 1, 300, ok);
      checks++; if (!ok) begin errors++; $display("FAIL midrst_first_timeout: got %0d starts expected 1", obs_q.size() - base); end
      repeat (3) tick();
      checks++; if (fifo_level !== 3'd3) begin errors++; $display("FAIL midrst_queued: got %0d expected 3", fifo_level); end
      rst_n = 1'b0;
      #1;
      checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL midrst_tx_start: got %b expected 0", tx_start); end
      checks++; if (fifo_level !== '0) begin errors++; $display("FAIL midrst_level: got %0d expected 0", fifo_level); end
      repeat (2) tick();
      rst_n = 1'b1;
      t_rel = cyc;
      base = obs_q.size();
      v = rnd_meas();
      tick();
      drive(2, v);
      tick();
      meas_valid = '0;
      wait_caps(base + 1, 300, ok);
      checks++;
      if (!ok) begin
         errors++; $display("FAIL midrst_next_timeout: got %0d starts expected 1", obs_q.size() - base);
      end else begin
         checks++;
         if (obs_t[base] - t_rel < CLKS || obs_t[base] - t_rel > CLKS + 5) begin
            errors++; $display("FAIL midrst_delay: got %0d cycles expected %0d..%0d", obs_t[base] - t_rel, CLKS, CLKS + 5);
         end
         checks++;
         if (obs_q[base] !== {8'd2, v}) begin errors++; $display("FAIL midrst_data: got %h expected %h", obs_q[base], {8'd2, v}); end
      end
      repeat (40) tick();
   endtask

   initial begin
      test_reset();
      test_first_tx_rate();
      test_all_channels();
      test_random_rr();
      test_overwrite_full();
      test_latest_only();
      test_busy_timeout();
      test_reset_mid_frame();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
